// File: rtl/i2c_pkg.sv
// Package: i2c_pkg
// Shared types and constants for the I2C write master.
//   state_t       - transaction FSM states
//   Q0..Q3        - quarter-phase encodings within one SCL bit time
//   I2C_WRITE/READ - R/W bit values appended to the 7-bit address
//   bus_drive_t   - {scl, sda} open-drain pull-down request pair
//   drive_levels  - bus levels for a given state, quarter and data bit
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    STOP
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

  // 1 = pull the line low, 0 = release it to the pull-up.
  typedef struct packed {
    logic scl;
    logic sda;
  } bus_drive_t;

  // Bus pull-down requests for the quarter 'ph' of a bit in state 'st'.
  // SCL is low in Q0/Q1 and released in Q2/Q3 for every clocked bit, so
  // SDA only changes while SCL is low except in START and STOP.
  function automatic bus_drive_t drive_levels(input state_t     st,
                                              input logic [1:0] ph,
                                              input logic       bit_val);
    bus_drive_t d;
    d.scl = 1'b0;
    d.sda = 1'b0;
    case (st)
      // SDA falls while SCL is high in the second half.
      START: d.sda = (ph >= Q2);
      ADDR, DATA: begin
        d.scl = (ph <= Q1);
        d.sda = ~bit_val;
      end
      // SDA released so the slave can answer.
      ADDR_ACK, DATA_ACK: d.scl = (ph <= Q1);
      // SDA held low, SCL released at Q2, SDA released at Q3 (rises with SCL high).
      STOP: begin
        d.scl = (ph <= Q1);
        d.sda = (ph != Q3);
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Module: i2c_tick_gen
// Quarter-bit timebase for the I2C master. Counts CLK_DIV clk cycles per
// quarter and advances a 2-bit phase on each quarter boundary.
// Ports:
//   clk, reset_n  - clock, synchronous active-low reset
//   en            - run the divider; when low the counter and phase sit at 0
//   hold          - freeze the divider (clock stretching by the slave)
//   tick          - one-clk pulse in the last clk of every quarter
//   phase         - current quarter Q0..Q3
module i2c_tick_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       hold,
  output logic       tick,
  output logic [1:0] phase
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && !hold && (cnt == LAST);

  always_ff @(posedge clk) begin
    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge values of its inputs regardless of block ordering.
    if (!reset_n || !en) begin
      cnt   <= '0;
      phase <= Q0;
    end else if (!hold) begin
      if (cnt == LAST) begin
        cnt   <= '0;
        phase <= phase + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_master_tx.sv
// Module: i2c_master_tx
// Single-byte I2C write master: START, address+W, one data byte, STOP on an
// open-drain SCL/SDA pair, sampling the slave ACK after each byte.
// Build option: define I2C_CLK_STRETCH_EN to let a slave holding SCL low in
// Q2/Q3 freeze the quarter timebase; otherwise scl_in is ignored.
// Ports:
//   clk, reset_n     - clock, synchronous active-low reset
//   start            - transaction request, accepted only while busy=0
//   addr, wdata      - 7-bit slave address and data byte, latched on accept
//   scl_in, sda_in   - resolved bus levels
//   scl_drv, sda_drv - 1 = pull the line low, 0 = release
//   busy             - transaction in progress
//   done             - one-clk pulse on return to IDLE
//   ack_err          - last transaction saw a NACK; cleared on accept
module i2c_master_tx
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_drv,
  output logic       sda_drv,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  state_t     state, nxt_state;
  logic [2:0] bit_cnt, nxt_bit;
  logic [7:0] addr_byte, data_byte;
  logic       ack_sample;
  logic       nxt_nack;
  logic       tick;
  logic [1:0] phase, nxt_phase;
  logic       hold;
  logic       bit_val;
  bus_drive_t nxt_drive;

`ifdef I2C_CLK_STRETCH_EN
  // Our SCL is released but the bus is still low: a slave is stretching.
  assign hold = (phase >= Q2) && !scl_drv && !scl_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign hold          = 1'b0;
`endif

  i2c_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (busy),
    .hold   (hold),
    .tick   (tick),
    .phase  (phase)
  );

  // Bit-boundary decisions; only the last quarter of a bit moves the FSM.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    nxt_state = state;
    nxt_bit   = bit_cnt;
    nxt_nack  = 1'b0;
    if (tick && phase == Q3) begin
      case (state)
        START: begin
          nxt_state = ADDR;
          nxt_bit   = 3'd7;
        end
        ADDR: begin
          if (bit_cnt == 3'd0) nxt_state = ADDR_ACK;
          else                 nxt_bit   = bit_cnt - 3'd1;
        end
        ADDR_ACK: begin
          if (ack_sample) begin
            nxt_state = STOP;
            nxt_nack  = 1'b1;
          end else begin
            nxt_state = DATA;
            nxt_bit   = 3'd7;
          end
        end
        DATA: begin
          if (bit_cnt == 3'd0) nxt_state = DATA_ACK;
          else                 nxt_bit   = bit_cnt - 3'd1;
        end
        DATA_ACK: begin
          nxt_state = STOP;
          nxt_nack  = ack_sample;
        end
        STOP:    nxt_state = IDLE;
        default: ;
      endcase
    end
  end

  // Outputs are registered one quarter ahead: on each tick we load the
  // levels belonging to the quarter that starts on this edge.
  assign nxt_phase = phase + 2'd1;
  assign bit_val   = (nxt_state == DATA) ? data_byte[nxt_bit] : addr_byte[nxt_bit];
  assign nxt_drive = drive_levels(nxt_state, nxt_phase, bit_val);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      addr_byte  <= 8'd0;
      data_byte  <= 8'd0;
      ack_sample <= 1'b0;
      scl_drv    <= 1'b0;
      sda_drv    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ack_err    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          state     <= START;
          addr_byte <= {addr, I2C_WRITE};
          data_byte <= wdata;
          ack_err   <= 1'b0;
          busy      <= 1'b1;
          scl_drv   <= 1'b0;
          sda_drv   <= 1'b0;
        end
      end else if (tick) begin
        state   <= nxt_state;
        bit_cnt <= nxt_bit;
        scl_drv <= nxt_drive.scl;
        sda_drv <= nxt_drive.sda;
        // ACK is read at the end of Q2, while SCL is high.
        if (phase == Q2 && (state == ADDR_ACK || state == DATA_ACK))
          ack_sample <= sda_in;
        if (nxt_nack)
          ack_err <= 1'b1;
        if (state == STOP && phase == Q3) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_tx.sv
// Testbench: tb_i2c_master_tx
// Drives i2c_master_tx (CLK_DIV=4) against a behavioural I2C slave on a
// pulled-up bus. Expected bus bytes are queued when a transaction is issued
// and compared against the bytes the slave captures.
module tb_i2c_master_tx;

  localparam int CLK_DIV = 4;
  localparam int LAT_ACK = 80 * CLK_DIV;
  localparam int LAT_ANK = 44 * CLK_DIV;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       scl_drv, sda_drv, busy, done, ack_err;
  logic       scl_bus, sda_bus;
  logic       stretch_low = 1'b0;
  logic       slave_sda = 1'b0;
  logic [1:0] ack_mask = 2'b11;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int start_seen = 0;
  int stop_seen = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  // Open-drain bus with pull-ups.
  assign scl_bus = !(scl_drv || stretch_low);
  assign sda_bus = !(sda_drv || slave_sda);

  i2c_master_tx #(
    .CLK_DIV(CLK_DIV)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .addr   (addr),
    .wdata  (wdata),
    .scl_in (scl_bus),
    .sda_in (sda_bus),
    .scl_drv(scl_drv),
    .sda_drv(sda_drv),
    .busy   (busy),
    .done   (done),
    .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Behavioural slave, sampled on the falling clk edge where the DUT is stable.
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       in_xfer = 1'b0;
  logic       ack_slot = 1'b0;
  int         bit_n = 0;
  int         byte_n = 0;
  logic [7:0] sh = '0;

  always @(negedge clk) begin
    if (prev_scl && scl_bus && prev_sda && !sda_bus) begin
      start_seen++;
      in_xfer = 1'b1; ack_slot = 1'b0; bit_n = 0; byte_n = 0; slave_sda = 1'b0;
    end else if (prev_scl && scl_bus && !prev_sda && sda_bus) begin
      stop_seen++;
      in_xfer = 1'b0; ack_slot = 1'b0; slave_sda = 1'b0;
    end else if (in_xfer && !prev_scl && scl_bus) begin
      if (!ack_slot && bit_n < 8) begin
        sh = {sh[6:0], sda_bus};
        bit_n++;
        if (bit_n == 8) got_q.push_back(sh);
      end
    end else if (in_xfer && prev_scl && !scl_bus) begin
      if (ack_slot) begin
        ack_slot = 1'b0; slave_sda = 1'b0; bit_n = 0; byte_n++;
      end else if (bit_n == 8) begin
        ack_slot  = 1'b1;
        slave_sda = (byte_n < 2) ? ack_mask[byte_n] : 1'b0;
      end
    end
    prev_scl = scl_bus;
    prev_sda = sda_bus;
  end

  // One transaction with scoreboard check. extra_start / st_on / st_off are
  // cycle offsets after accept (-1 = unused).
  task automatic run_txn(input string name, input logic [6:0] a, input logic [7:0] d,
                         input logic [1:0] mask, input int exp_lat, input int extra_start,
                         input int st_on, input int st_off);
    int   t0, el, lat, dc0, sc0, ss0, n_exp;
    bit   got_done;
    logic exp_err;
    logic [7:0] eb, gb;
    exp_err  = !mask[0] || !mask[1];
    exp_q.delete();
    got_q.delete();
    exp_q.push_back({a, 1'b0});
    if (mask[0]) exp_q.push_back(d);
    ack_mask = mask;
    dc0 = done_cnt; sc0 = stop_seen; ss0 = start_seen;
    lat = -1; got_done = 0;

    @(negedge clk);
    addr = a; wdata = d; start = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL %s busy_after_accept: got %b want 1", name, busy);
    end
    n_cmp++;
    if (ack_err !== 1'b0) begin
      n_err++; $display("FAIL %s ack_err_cleared: got %b want 0", name, ack_err);
    end

    for (int k = 0; k < 2000 && !got_done; k++) begin
      @(negedge clk);
      el = cyc - t0;
      start = (el == extra_start);
      if (el == st_on)  stretch_low = 1'b1;
      if (el == st_off) stretch_low = 1'b0;
      if (done === 1'b1) begin
        got_done = 1; lat = el;
      end
    end
    start = 1'b0; stretch_low = 1'b0;

    n_cmp++;
    if (!got_done) begin
      n_err++; $display("FAIL %s done_timeout: got none want pulse", name);
    end else if (lat != exp_lat) begin
      n_err++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    n_cmp++;
    if (ack_err !== exp_err) begin
      n_err++; $display("FAIL %s ack_err: got %b want %b", name, ack_err, exp_err);
    end
    n_cmp++;
    if ({busy, scl_drv, sda_drv} !== 3'b000) begin
      n_err++; $display("FAIL %s idle_at_done: got busy/scl/sda=%b want 000", name,
                        {busy, scl_drv, sda_drv});
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL %s done_width: got %b want 0", name, done);
    end
    repeat (40) @(negedge clk);
    n_cmp++;
    if (done_cnt - dc0 != 1) begin
      n_err++; $display("FAIL %s done_count: got %0d want 1", name, done_cnt - dc0);
    end
    n_cmp++;
    if (start_seen - ss0 != 1 || stop_seen - sc0 != 1) begin
      n_err++; $display("FAIL %s start_stop: got %0d/%0d want 1/1", name,
                        start_seen - ss0, stop_seen - sc0);
    end

    n_exp = exp_q.size();
    for (int i = 0; i < n_exp; i++) begin
      eb = exp_q.pop_front();
      n_cmp++;
      if (got_q.size() == 0) begin
        n_err++; $display("FAIL %s byte%0d: got none want %h", name, i, eb);
      end else begin
        gb = got_q.pop_front();
        if (gb !== eb) begin
          n_err++; $display("FAIL %s byte%0d: got %h want %h", name, i, gb, eb);
        end
      end
    end
    n_cmp++;
    if (got_q.size() != 0) begin
      n_err++; $display("FAIL %s extra_bytes: got %0d want 0", name, got_q.size());
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({scl_drv, sda_drv, busy, done, ack_err} !== 5'b0) begin
      n_err++; $display("FAIL reset_outputs: got %b want 00000",
                        {scl_drv, sda_drv, busy, done, ack_err});
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ack_path;
    run_txn("ack_path", 7'h55, 8'hA5, 2'b11, LAT_ACK, -1, -1, -1);
  endtask

  task automatic test_addr_nack;
    run_txn("addr_nack", 7'h12, 8'h3C, 2'b00, LAT_ANK, -1, -1, -1);
  endtask

  task automatic test_data_nack;
    run_txn("data_nack", 7'h55, 8'h5A, 2'b01, LAT_ACK, -1, -1, -1);
  endtask

  task automatic test_back_to_back;
    run_txn("start_ignored", 7'h7F, 8'h00, 2'b11, LAT_ACK, 40, -1, -1);
  endtask

  task automatic test_reset_mid;
    int t0, dc;
    ack_mask = 2'b11;
    @(negedge clk);
    addr = 7'h55; wdata = 8'hA5; start = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    // Offset 86 falls inside address bit 3 (bits start 16 clk apart after START).
    for (int k = 0; k < 200 && (cyc - t0) < 86; k++) @(negedge clk);
    dc = done_cnt;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({scl_drv, sda_drv, busy, done} !== 4'b0) begin
      n_err++; $display("FAIL reset_mid_outputs: got %b want 0000",
                        {scl_drv, sda_drv, busy, done});
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (done_cnt != dc) begin
      n_err++; $display("FAIL reset_mid_no_done: got %0d want 0", done_cnt - dc);
    end
    run_txn("after_reset", 7'h2B, 8'h81, 2'b11, LAT_ACK, -1, -1, -1);
  endtask

`ifdef I2C_CLK_STRETCH_EN
  task automatic test_stretch;
    // ADDR_ACK Q2 begins 152 clk after accept; hold SCL low across it so the
    // divider freezes for 30 clk.
    run_txn("stretch", 7'h55, 8'h3C, 2'b11, LAT_ACK + 30, -1, 150, 182);
  endtask
`endif

  initial begin
    test_reset();
    test_ack_path();
    test_addr_nack();
    test_data_nack();
    test_back_to_back();
    test_reset_mid();
`ifdef I2C_CLK_STRETCH_EN
    test_stretch();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "simulation time limit");
  end

endmodule
